// File: rtl/oam_dma_engine_if.sv
// -----------------------------------------------------------------------------
// oam_dma_engine_if
//
// Shared CPU-bus bundle between the OAM DMA engine, the CPU core it snoops and
// the memory/IO fabric it drives while it owns the bus.
//
// Signals:
//   cpu_addr   [15:0]  CPU bus address, snooped for the trigger write
//   cpu_data_o [7:0]   CPU write data (trigger page number)
//   cpu_we             CPU write strobe
//   mem_data_i [7:0]   combinational read data from the fabric for dma_addr
//   cpu_rdy            CPU ready, 0 while the CPU is halted
//   dma_active         bus grant, 1 while the dma_* signals own the bus
//   dma_addr   [15:0]  DMA bus address
//   dma_data_o [7:0]   DMA write data
//   dma_we             DMA write strobe
//   dma_done           one-cycle pulse at the end of a transfer
//
// Modports:
//   master  the DMA engine side
//   slave   the CPU/fabric side (drives snoop and read data, observes DMA)
// -----------------------------------------------------------------------------
interface oam_dma_engine_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_o;
    logic        cpu_we;
    logic [7:0]  mem_data_i;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_o;
    logic        dma_we;
    logic        dma_done;

    modport master (
        input  cpu_addr, cpu_data_o, cpu_we, mem_data_i,
        output cpu_rdy, dma_active, dma_addr, dma_data_o, dma_we, dma_done
    );

    modport slave (
        output cpu_addr, cpu_data_o, cpu_we, mem_data_i,
        input  cpu_rdy, dma_active, dma_addr, dma_data_o, dma_we, dma_done
    );
endinterface

// File: rtl/oam_dma_engine.sv
// -----------------------------------------------------------------------------
// oam_dma_engine
//
// Sprite OAM DMA initiator. A CPU write to TRIG_ADDR latches a page number,
// halts the CPU and then copies XFER_LEN bytes from {page, 8'h00..} to the OAM
// data port OAM_ADDR as read/write pairs on the shared CPU bus.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous, active-high reset
//   bus   oam_dma_engine_if.master (snooped CPU write, fabric read data,
//         cpu_rdy / dma_active / dma_addr / dma_data_o / dma_we / dma_done)
//
// Parameters:
//   TRIG_ADDR  CPU write address that starts a transfer
//   OAM_ADDR   destination address of every write cycle
//   XFER_LEN   bytes per transfer, power of two, at most 256
//
// Build option:
//   OAM_DMA_ALIGN_EN  when defined, a HALT cycle landing on a put cycle
//                     (parity 1) is followed by one idle ALIGN cycle so the
//                     first read happens on a get cycle. When undefined the
//                     parity toggle is not built and HALT always goes to READ.
//
// All outputs are registered. Halt length is 1 + align + 2*XFER_LEN cycles.
// -----------------------------------------------------------------------------
module oam_dma_engine #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] OAM_ADDR  = 16'h2004,
    parameter int          XFER_LEN  = 256
) (
    input  logic              clk,
    input  logic              rst,
    oam_dma_engine_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_e      state_q;
    logic [7:0]  page_q;
    logic [7:0]  idx_q;
    logic [7:0]  idx_d;
    logic        cpu_rdy_q;
    logic        dma_active_q;
    logic [15:0] dma_addr_q;
    logic [7:0]  dma_data_q;
    logic        dma_we_q;
    logic        dma_done_q;
`ifdef OAM_DMA_ALIGN_EN
    logic        parity_q;     // 0 = get cycle, 1 = put cycle
`endif

    logic        trig;
    logic [15:0] rd_addr;

    // Only a write to the trigger address counts; reads of it are ignored.
    assign trig    = bus.cpu_we && (bus.cpu_addr == TRIG_ADDR);
    // Page is fixed for the whole transfer, so the read address never
    // carries into the next page.
    assign rd_addr = {page_q, idx_q};
    assign idx_d   = idx_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            page_q       <= 8'h00;
            idx_q        <= 8'h00;
            cpu_rdy_q    <= 1'b1;
            dma_active_q <= 1'b0;
            dma_addr_q   <= 16'h0000;
            dma_data_q   <= 8'h00;
            dma_we_q     <= 1'b0;
            dma_done_q   <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
            parity_q     <= 1'b0;
`endif
        end else begin
`ifdef OAM_DMA_ALIGN_EN
            parity_q   <= ~parity_q;
`endif
            dma_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Also reached in the dma_done cycle, which is what makes
                    // back-to-back transfers possible.
                    if (trig) begin
                        page_q       <= bus.cpu_data_o;
                        state_q      <= HALT;
                        cpu_rdy_q    <= 1'b0;
                        dma_active_q <= 1'b1;
                    end
                end

                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    if (parity_q) begin
                        state_q <= ALIGN;
                    end else begin
                        state_q    <= READ;
                        dma_addr_q <= rd_addr;
                    end
`else
                    state_q    <= READ;
                    dma_addr_q <= rd_addr;
`endif
                end

                ALIGN: begin
                    state_q    <= READ;
                    dma_addr_q <= rd_addr;
                end

                READ: begin
                    // mem_data_i answers dma_addr within this cycle.
                    dma_data_q <= bus.mem_data_i;
                    dma_addr_q <= OAM_ADDR;
                    dma_we_q   <= 1'b1;
                    state_q    <= WRITE;
                end

                WRITE: begin
                    dma_we_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        // Bus handed back in the same cycle as the done pulse;
                        // dma_addr / dma_data_o keep their last values.
                        idx_q        <= 8'h00;
                        state_q      <= IDLE;
                        dma_done_q   <= 1'b1;
                        cpu_rdy_q    <= 1'b1;
                        dma_active_q <= 1'b0;
                    end else begin
                        idx_q      <= idx_d;
                        dma_addr_q <= {page_q, idx_d};
                        state_q    <= READ;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdy    = cpu_rdy_q;
    assign bus.dma_active = dma_active_q;
    assign bus.dma_addr   = dma_addr_q;
    assign bus.dma_data_o = dma_data_q;
    assign bus.dma_we     = dma_we_q;
    assign bus.dma_done   = dma_done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// -----------------------------------------------------------------------------
// tb_oam_dma_engine
//
// Directed bench for oam_dma_engine. The fabric is a pattern function of the
// address; every transfer is walked cycle by cycle against the expected
// HALT / (ALIGN) / READ / WRITE sequence and the done cycle.
// -----------------------------------------------------------------------------
module tb_oam_dma_engine;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) passes++; else $error("FAIL %s: got %0h, expected %0h", tag, (obs), (exp)); end

    logic clk;
    logic rst;
    logic tb_par;   // expected parity of the current cycle
    int   checks;
    int   passes;

    oam_dma_engine_if bus ();

    oam_dma_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

    function automatic logic [7:0] pat(input logic [7:0] pg, input logic [7:0] n);
        case (pg)
            8'h02:   return n ^ 8'h5A;
            8'h03:   return n ^ 8'hA5;
            8'hFF:   return n ^ 8'h33;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.mem_data_i = pat(bus.dma_addr[15:8], bus.dma_addr[7:0]);

    function automatic logic exp_align(input logic halt_par);
`ifdef OAM_DMA_ALIGN_EN
        return halt_par;
`else
        return 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue the trigger write so that the HALT cycle lands on halt_par.
    task automatic trigger(input logic [7:0] pg, input logic halt_par);
        if (tb_par !== ~halt_par) step();
        bus.cpu_addr   = 16'h4014;
        bus.cpu_data_o = pg;
        bus.cpu_we     = 1'b1;
        step();
        bus.cpu_addr   = 16'h0000;
        bus.cpu_data_o = 8'h00;
        bus.cpu_we     = 1'b0;
    endtask

    // Entered in the HALT cycle; returns in the dma_done cycle.
    task automatic xfer(input logic [7:0] pg, input logic align);
        int          halted;
        int          bad_ctl;
        int          bad_rd;
        int          bad_wr;
        logic [15:0] last_rd;
        logic [15:0] exp_last;
        int          exp_halt;
        halted  = 0;
        bad_ctl = 0;
        bad_rd  = 0;
        bad_wr  = 0;
        last_rd = 16'h0000;
        for (int k = 0; k < (align ? 2 : 1); k++) begin
            if (bus.cpu_rdy === 1'b0) halted++;
            if (bus.dma_active !== 1'b1 || bus.dma_we !== 1'b0 || bus.dma_done !== 1'b0) bad_ctl++;
            step();
        end
        for (int n = 0; n < 256; n++) begin
            if (bus.cpu_rdy === 1'b0) halted++;
            if (bus.dma_active !== 1'b1 || bus.dma_done !== 1'b0) bad_ctl++;
            if (bus.dma_addr !== {pg, 8'(n)} || bus.dma_we !== 1'b0) bad_rd++;
            last_rd = bus.dma_addr;
            step();
            if (bus.cpu_rdy === 1'b0) halted++;
            if (bus.dma_active !== 1'b1 || bus.dma_done !== 1'b0) bad_ctl++;
            if (bus.dma_addr !== 16'h2004 || bus.dma_we !== 1'b1 ||
                bus.dma_data_o !== pat(pg, 8'(n))) bad_wr++;
            step();
        end
        exp_halt = align ? 514 : 513;
        exp_last = {pg, 8'hFF};
        `CHK("done_pulse", bus.dma_done, 1'b1)
        `CHK("done_rdy", bus.cpu_rdy, 1'b1)
        `CHK("done_active", bus.dma_active, 1'b0)
        `CHK("done_we", bus.dma_we, 1'b0)
        `CHK("halt_len", halted, exp_halt)
        `CHK("halt_ctl_errs", bad_ctl, 0)
        `CHK("read_errs", bad_rd, 0)
        `CHK("write_errs", bad_wr, 0)
        `CHK("last_read", last_rd, exp_last)
    endtask

    initial begin
        int   quiet_bad;
        logic hp;
        checks         = 0;
        passes         = 0;
        rst            = 1'b1;
        bus.cpu_addr   = 16'h0000;
        bus.cpu_data_o = 8'h00;
        bus.cpu_we     = 1'b0;
        repeat (3) step();

        // Reset state
        `CHK("rst_rdy", bus.cpu_rdy, 1'b1)
        `CHK("rst_active", bus.dma_active, 1'b0)
        `CHK("rst_addr", bus.dma_addr, 16'h0000)
        `CHK("rst_data", bus.dma_data_o, 8'h00)
        `CHK("rst_we", bus.dma_we, 1'b0)
        `CHK("rst_done", bus.dma_done, 1'b0)
        rst = 1'b0;
        step();

        // Write to $4015 and a read of $4014 must not start anything
        quiet_bad = 0;
        bus.cpu_addr = 16'h4015; bus.cpu_data_o = 8'h02; bus.cpu_we = 1'b1;
        step();
        bus.cpu_addr = 16'h4014; bus.cpu_we = 1'b0;
        step();
        bus.cpu_addr = 16'h0000; bus.cpu_data_o = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0 || bus.dma_we !== 1'b0) quiet_bad++;
            step();
        end
        `CHK("no_trigger", quiet_bad, 0)

        // Page 2, HALT on parity 0
        trigger(8'h02, 1'b0);
        xfer(8'h02, 1'b0);
        step();
        `CHK("idle_done_clear", bus.dma_done, 1'b0)
        `CHK("idle_addr_hold", bus.dma_addr, 16'h2004)
        `CHK("idle_data_hold", bus.dma_data_o, 8'hA5)

        // Page 2, HALT on parity 1
        trigger(8'h02, 1'b1);
        xfer(8'h02, exp_align(1'b1));
        step();

        // Page $FF stays inside the page
        trigger(8'hFF, 1'b0);
        xfer(8'hFF, 1'b0);
        step();
        `CHK("ff_addr_hold", bus.dma_addr, 16'h2004)
        `CHK("ff_state_idle", bus.cpu_rdy, 1'b1)

        // Reset at halted cycle 100
        trigger(8'h02, 1'b0);
        repeat (99) step();
        `CHK("mid_halted", bus.cpu_rdy, 1'b0)
        rst = 1'b1;
        step();
        rst = 1'b0;
        `CHK("mid_rst_rdy", bus.cpu_rdy, 1'b1)
        `CHK("mid_rst_active", bus.dma_active, 1'b0)
        `CHK("mid_rst_we", bus.dma_we, 1'b0)
        `CHK("mid_rst_done", bus.dma_done, 1'b0)
        quiet_bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.dma_done !== 1'b0 || bus.cpu_rdy !== 1'b1) quiet_bad++;
        end
        `CHK("mid_rst_quiet", quiet_bad, 0)
        trigger(8'h02, 1'b0);
        xfer(8'h02, 1'b0);
        step();

        // Back-to-back: second trigger sampled in the dma_done cycle
        trigger(8'h02, 1'b0);
        xfer(8'h02, 1'b0);
        hp = ~tb_par;
        bus.cpu_addr = 16'h4014; bus.cpu_data_o = 8'h03; bus.cpu_we = 1'b1;
        step();
        bus.cpu_addr = 16'h0000; bus.cpu_data_o = 8'h00; bus.cpu_we = 1'b0;
        `CHK("b2b_halt", bus.cpu_rdy, 1'b0)
        xfer(8'h03, exp_align(hp));
        step();
        `CHK("b2b_done_clear", bus.dma_done, 1'b0)

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
